// File: rtl/kbd_ctrl.sv
// Keyboard IOT controller: latches received characters and services KCF/KSF/KCC/KRS/KIE/KRB
// IOT instructions through a three-state IDLE/EXEC/DONE sequence.
module kbd_ctrl #(
    parameter logic [5:0] DEV = 6'o03
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        iot,
    input  logic [5:0]  dev,
    input  logic [2:0]  op,
    input  logic [0:11] ac_in,
    input  logic        rx_flag,
    input  logic [0:7]  rx_char,
    output logic        rx_clear_flag,
    output logic        ack,
    output logic        skip,
    output logic        ac_clear,
    output logic        ac_or,
    output logic [0:11] ac_out,
    output logic        int_req,
    output logic        ie,
    output logic        overrun
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_r;
    logic [2:0]  op_r;
    logic [0:7]  buffer_r;
    logic        kbd_flag_r;
    logic        rx_q_r;

    logic        start_s;
    logic        rise_s;
    logic        exec_clr_s;
    logic        kbd_next_s;
    logic        ovr_next_s;
    logic        unused_s;

    // op bit 2 carries the value-1 bit, op bit 0 the value-4 bit; KIE (value 5) is symmetric
    function automatic logic is_kie(input logic [2:0] o);
        return (o == 3'b101);
    endfunction

    assign ac_out   = {4'b0000, buffer_r};
    assign unused_s = ^ac_in[0:10];

    // Next-state of the character flag and overrun; a new character beats a same-cycle clear
    always_comb begin
        start_s    = 1'b0;
        rise_s     = 1'b0;
        exec_clr_s = 1'b0;
        kbd_next_s = kbd_flag_r;
        ovr_next_s = overrun;
        start_s    = (state_r == ST_IDLE) && iot && (dev == DEV);
        rise_s     = rx_flag && !rx_q_r;
        exec_clr_s = (state_r == ST_EXEC) && !is_kie(op_r) && op_r[1];
        if (exec_clr_s) begin
            kbd_next_s = rise_s;
            ovr_next_s = 1'b0;
        end else if (rise_s) begin
            kbd_next_s = 1'b1;
            ovr_next_s = overrun | kbd_flag_r;
        end else begin
            kbd_next_s = kbd_flag_r;
            ovr_next_s = overrun;
        end
    end

    // Sequencer, receive buffer and all registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            op_r          <= 3'b000;
            buffer_r      <= 8'h00;
            kbd_flag_r    <= 1'b0;
            overrun       <= 1'b0;
            ie            <= 1'b1;
            int_req       <= 1'b0;
            rx_q_r        <= 1'b1;
            skip          <= 1'b0;
            ack           <= 1'b0;
            ac_clear      <= 1'b0;
            ac_or         <= 1'b0;
            rx_clear_flag <= 1'b0;
        end else if (clear) begin
            state_r       <= ST_IDLE;
            op_r          <= 3'b000;
            buffer_r      <= 8'h00;
            kbd_flag_r    <= 1'b0;
            overrun       <= 1'b0;
            ie            <= 1'b1;
            int_req       <= 1'b0;
            rx_q_r        <= 1'b1;
            skip          <= 1'b0;
            ack           <= 1'b0;
            ac_clear      <= 1'b0;
            ac_or         <= 1'b0;
            rx_clear_flag <= 1'b0;
        end else begin
            rx_q_r        <= rx_flag;
            kbd_flag_r    <= kbd_next_s;
            overrun       <= ovr_next_s;
            int_req       <= kbd_flag_r & ie;
            skip          <= 1'b0;
            ack           <= 1'b0;
            ac_clear      <= 1'b0;
            ac_or         <= 1'b0;
            rx_clear_flag <= 1'b0;
            if (rise_s) begin
                buffer_r <= rx_char;
            end else begin
                buffer_r <= buffer_r;
            end
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        state_r       <= ST_EXEC;
                        op_r          <= op;
                        // pulses are staged here so they are visible for the whole EXEC cycle
                        skip          <= !is_kie(op) && op[2] && kbd_next_s;
                        ac_clear      <= !is_kie(op) && op[1];
                        rx_clear_flag <= !is_kie(op) && op[1];
                        ac_or         <= !is_kie(op) && op[0];
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    state_r <= ST_DONE;
                    ack     <= 1'b1;
                    if (is_kie(op_r)) begin
                        ie <= ac_in[11];
                    end else begin
                        ie <= ie;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kbd_ctrl.sv
// Self-checking bench for kbd_ctrl: directed scenarios followed by randomized character
// arrivals and IOTs, compared against a transaction-level model of the keyboard state.
module tb_kbd_ctrl;

    logic        clk = 1'b0;
    logic        reset, clear, iot, rx_flag;
    logic [5:0]  dev;
    logic [2:0]  op;
    logic [0:11] ac_in;
    logic [0:7]  rx_char;
    logic        rx_clear_flag, ack, skip, ac_clear, ac_or, int_req, ie, overrun;
    logic [0:11] ac_out;

    int n_tests = 0;
    int n_fail  = 0;

    // model of the architecturally visible keyboard state
    bit         m_flag, m_ov, m_ie;
    logic [7:0] m_buf;

    kbd_ctrl #(.DEV(6'o03)) dut (
        .clk(clk), .reset(reset), .clear(clear), .iot(iot), .dev(dev), .op(op),
        .ac_in(ac_in), .rx_flag(rx_flag), .rx_char(rx_char),
        .rx_clear_flag(rx_clear_flag), .ack(ack), .skip(skip), .ac_clear(ac_clear),
        .ac_or(ac_or), .ac_out(ac_out), .int_req(int_req), .ie(ie), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_flag = 1'b0;
        m_ov   = 1'b0;
        m_ie   = 1'b1;
        m_buf  = 8'h00;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_ie"},  32'(ie),      32'(m_ie));
        check({tag, "_ovr"}, 32'(overrun), 32'(m_ov));
        check({tag, "_irq"}, 32'(int_req), 32'(m_flag & m_ie));
        check({tag, "_buf"}, 32'(ac_out),  32'({4'b0000, m_buf}));
    endtask

    task automatic send_char(input logic [7:0] c);
        rx_flag = 1'b0;
        step();
        rx_flag = 1'b1;
        rx_char = c;
        step();
        if (m_flag) m_ov = 1'b1;
        m_flag = 1'b1;
        m_buf  = c;
        check("char_buf", 32'(ac_out), 32'({4'b0000, m_buf}));
        step();
        check_state("char");
    endtask

    // val is the instruction-level op value (1=skip, 2=clear, 4=read)
    task automatic do_iot(input logic [2:0] val, input logic [5:0] d, input logic [11:0] acv,
                          input bit coinc, input logic [7:0] c);
        bit hit, kie, clr;
        logic [7:0] old_buf;
        hit = (d == 6'o03);
        kie = (val == 3'd5);
        clr = hit && !kie && val[1];
        if (coinc) begin
            rx_flag = 1'b0;
            step();
        end
        old_buf = m_buf;
        iot   = 1'b1;
        dev   = d;
        op    = {val[0], val[1], val[2]};
        ac_in = acv;
        step();
        iot = 1'b0;
        if (coinc) begin
            rx_flag = 1'b1;
            rx_char = c;
        end
        check("exec_skip",  32'(skip),          32'(hit && !kie && val[0] && m_flag));
        check("exec_clr",   32'(ac_clear),      32'(clr));
        check("exec_rxclr", 32'(rx_clear_flag), 32'(clr));
        check("exec_or",    32'(ac_or),         32'(hit && !kie && val[2]));
        check("exec_acout", 32'(ac_out),        32'({4'b0000, old_buf}));
        check("exec_ack",   32'(ack),           32'd0);
        step();
        check("done_ack",   32'(ack), 32'(hit));
        check("done_pulse", 32'({skip, ac_clear, ac_or, rx_clear_flag}), 32'd0);
        if (hit && kie) m_ie = acv[0];
        if (clr) begin
            m_flag = 1'b0;
            m_ov   = 1'b0;
        end
        if (coinc) begin
            if (!clr && m_flag) m_ov = 1'b1;
            m_flag = 1'b1;
            m_buf  = c;
        end
        step();
        check("idle_ack", 32'(ack), 32'd0);
        check_state("iot");
    endtask

    // abort an IOT in its EXEC cycle by async reset (kind=0) or sync clear (kind=1)
    task automatic abort_iot(input bit kind);
        iot = 1'b1;
        dev = 6'o03;
        op  = 3'b011;
        step();
        iot = 1'b0;
        if (kind) begin
            clear = 1'b1;
            step();
            clear = 1'b0;
        end else begin
            reset = 1'b0;
            #2;
            check("rst_ack_now", 32'(ack), 32'd0);
            check("rst_ie_now",  32'(ie),  32'd1);
            reset = 1'b1;
        end
        model_reset();
        check("abort_pulse", 32'({skip, ac_clear, ac_or, rx_clear_flag, ack}), 32'd0);
        step();
        check("abort_ack1", 32'(ack), 32'd0);
        step();
        check("abort_ack2", 32'(ack), 32'd0);
        check_state("abort");
    endtask

    initial begin
        reset = 1'b0; clear = 1'b0; iot = 1'b0; dev = 6'o00; op = 3'b000;
        ac_in = 12'o0000; rx_flag = 1'b0; rx_char = 8'h00;
        model_reset();
        #12;
        reset = 1'b1;
        step();
        check("rst_ack", 32'(ack), 32'd0);
        check_state("rst");

        send_char(8'o301);
        check("krb_buf", 32'(ac_out), 32'(12'o0301));
        do_iot(3'd6, 6'o03, 12'o0000, 1'b0, 8'h00);
        do_iot(3'd1, 6'o03, 12'o0000, 1'b0, 8'h00);
        send_char(8'o101);
        do_iot(3'd1, 6'o03, 12'o0000, 1'b0, 8'h00);
        do_iot(3'd5, 6'o03, 12'o0000, 1'b0, 8'h00);
        do_iot(3'd5, 6'o03, 12'o0001, 1'b0, 8'h00);
        send_char(8'o102);
        send_char(8'o103);
        check("ovr_set", 32'(overrun), 32'd1);
        do_iot(3'd2, 6'o03, 12'o0000, 1'b0, 8'h00);
        do_iot(3'd2, 6'o03, 12'o0000, 1'b1, 8'o123);
        do_iot(3'd6, 6'o04, 12'o0000, 1'b0, 8'h00);
        abort_iot(1'b0);
        abort_iot(1'b1);

        for (int i = 0; i < 120; i++) begin
            int act;
            act = int'($urandom_range(0, 9));
            if (act < 3) begin
                send_char(8'($urandom));
            end else if (act < 7) begin
                do_iot(3'($urandom), 6'o03, 12'($urandom), 1'b0, 8'h00);
            end else if (act == 7) begin
                do_iot(3'($urandom), 6'o03, 12'($urandom), 1'b1, 8'($urandom));
            end else if (act == 8) begin
                do_iot(3'($urandom), 6'($urandom_range(4, 63)), 12'($urandom),
                       1'($urandom), 8'($urandom));
            end else begin
                abort_iot(1'($urandom));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
